// File: rtl/ste_dma_fifo.sv
// ste_dma_fifo - STE floppy/ACSI DMA FIFO, the requesting side of the
// GSTMCU RDY word-DMA handshake.
//
// Device bytes are buffered in a 2*BURST_WORDS byte FIFO. When a full burst
// is available (read dir) or the FIFO is empty with sectors still to move
// (write dir), RDY_O is pulled low. The MCU then answers each word with a
// RDY_I strobe that consumes DOUT or supplies DIN.
//
// Optional feature: define DMA_DONE_IRQ_EN to add the irq output. irq is
// raised when the sector count reaches zero through a byte-counter wrap.
//
// Ports:
//   clk32, reset         system clock, synchronous active-high reset
//   clk_en               8 MHz enable; all CPU/MCU bus sampling is gated by it
//   FCS_N, RW, A1, DIN   CPU register access (A1=1 mode/status, A1=0 count)
//   DOUT                 register read data, or FIFO head word during a burst
//   RDY_I                MCU word strobe, active low
//   RDY_O                burst request to the MCU, active low
//   dev_rd_*             device->FIFO byte stream (disk read)
//   dev_wr_*             FIFO->device byte stream (disk write)
//   irq                  sector count done (DMA_DONE_IRQ_EN only)
module ste_dma_fifo #(
  parameter int BURST_WORDS  = 8,
  parameter int SECTOR_BYTES = 512
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        FCS_N,
  input  logic        RW,
  input  logic        A1,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        RDY_I,
  output logic        RDY_O,
  input  logic        dev_rd_valid,
  output logic        dev_rd_ready,
  input  logic [7:0]  dev_rd_data,
  output logic        dev_wr_valid,
  input  logic        dev_wr_ready,
  output logic [7:0]  dev_wr_data
`ifdef DMA_DONE_IRQ_EN
  , output logic      irq
`endif
);

  localparam int DEPTH = 2 * BURST_WORDS;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BURST_WORDS);
  localparam int CW    = $clog2(SECTOR_BYTES);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr1;
  logic [AW:0]     cnt;
  logic [15:0]     mode;
  logic [7:0]      sc;
  logic            error;
  logic [CW-1:0]   bcnt;
  logic [BW-1:0]   wcnt;
  logic            wr_done;

  logic dir, full, empty;
  logic cpu_wr, mode_wr, sc_wr, dir_flip;
  logic strobe, burst_op, burst_last;
  logic rd_xfer, wr_xfer, dev_xfer, wrap;
  logic push_word, push_byte;
  logic [15:0] reg_rd;

  assign dir     = mode[8];
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign rd_ptr1 = rd_ptr + AW'(1);

  // One capture per chip-select assertion: wr_done blocks repeats until
  // FCS_N goes high again.
  assign cpu_wr   = clk_en && !FCS_N && !RW && !wr_done;
  assign mode_wr  = cpu_wr && A1;
  assign sc_wr    = cpu_wr && !A1 && mode[4];
  assign dir_flip = mode_wr && (DIN[8] != mode[8]);

  assign strobe     = clk_en && !RDY_I;
  assign burst_op   = (state_q == BURST) && strobe;
  assign burst_last = burst_op && (wcnt == BW'(BURST_WORDS-1));

  assign RDY_O        = (state_q != BURST);
  assign dev_rd_ready = !dir && !full && (sc != '0) && (state_q == IDLE);
  assign dev_wr_valid = dir && !empty && (state_q == IDLE);
  assign dev_wr_data  = mem[rd_ptr];

  assign rd_xfer  = dev_rd_valid && dev_rd_ready;
  assign wr_xfer  = dev_wr_valid && dev_wr_ready;
  assign dev_xfer = rd_xfer || wr_xfer;
  assign wrap     = dev_xfer && (bcnt == CW'(SECTOR_BYTES-1));

  // Device and MCU sides are mutually exclusive by state, so at most one
  // FIFO operation happens per cycle.
  assign push_word = burst_op && dir && !dir_flip;
  assign push_byte = rd_xfer && !dir_flip;

  assign reg_rd = A1      ? {13'b0, !RDY_O, (sc != '0), !error} :
                  mode[4] ? {8'h00, sc} : 16'h0000;

  always_comb begin
    DOUT = 16'h0000;
    if (!FCS_N && RW)
      DOUT = reg_rd;
    else if (!RDY_O && !dir)
      DOUT = {mem[rd_ptr], mem[rd_ptr1]};   // earlier byte in the high half
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((!dir && full) || (dir && empty && (sc != '0))) state_d = BURST;
      BURST:   if (burst_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dir_flip) state_d = IDLE;
  end

  // FIFO storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk32) begin
    if (push_word) begin
      mem[wr_ptr]          <= DIN[15:8];
      mem[wr_ptr + AW'(1)] <= DIN[7:0];
    end else if (push_byte) begin
      mem[wr_ptr] <= dev_rd_data;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset || dir_flip) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (burst_op && !dir) begin
      rd_ptr <= rd_ptr + AW'(2);
      cnt    <= cnt - (AW+1)'(2);
    end else if (push_word) begin
      wr_ptr <= wr_ptr + AW'(2);
      cnt    <= cnt + (AW+1)'(2);
    end else if (push_byte) begin
      wr_ptr <= wr_ptr + AW'(1);
      cnt    <= cnt + (AW+1)'(1);
    end else if (wr_xfer) begin
      rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q <= IDLE;
      mode    <= '0;
      sc      <= '0;
      error   <= 1'b0;
      bcnt    <= '0;
      wcnt    <= '0;
      wr_done <= 1'b0;
    end else begin
      state_q <= state_d;

      if (FCS_N)       wr_done <= 1'b0;
      else if (cpu_wr) wr_done <= 1'b1;

      if (mode_wr) mode <= DIN;

      if (dir_flip || burst_last) wcnt <= '0;
      else if (burst_op)          wcnt <= wcnt + BW'(1);

      // A strobe with no burst outstanding is a protocol error.
      if (dir_flip)                           error <= 1'b0;
      else if (strobe && (state_q == IDLE))   error <= 1'b1;

      if (dir_flip)      bcnt <= '0;
      else if (wrap)     bcnt <= '0;
      else if (dev_xfer) bcnt <= bcnt + CW'(1);

      // A CPU write beats the wrap decrement on the same cycle.
      if (dir_flip)                 sc <= '0;
      else if (sc_wr)               sc <= DIN[7:0];
      else if (wrap && (sc != '0))  sc <= sc - 8'd1;
    end
  end

`ifdef DMA_DONE_IRQ_EN
  always_ff @(posedge clk32) begin
    if (reset || mode_wr)
      irq <= 1'b0;
    else if (wrap && (sc == 8'd1) && !sc_wr)
      irq <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ste_dma_fifo.sv
// Directed bench for ste_dma_fifo: register table, read/write bursts,
// sector end, error flag, direction abort and reset mid-burst.
module tb_ste_dma_fifo;

  logic        clk32 = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en;
  logic        FCS_N = 1'b1;
  logic        RW    = 1'b1;
  logic        A1    = 1'b0;
  logic [15:0] DIN   = 16'h0000;
  logic [15:0] DOUT;
  logic        RDY_I = 1'b1;
  logic        RDY_O;
  logic        dev_rd_valid = 1'b0;
  logic        dev_rd_ready;
  logic [7:0]  dev_rd_data = 8'h00;
  logic        dev_wr_valid;
  logic        dev_wr_ready = 1'b0;
  logic [7:0]  dev_wr_data;
`ifdef DMA_DONE_IRQ_EN
  logic        irq;
`endif

  ste_dma_fifo dut (
`ifdef DMA_DONE_IRQ_EN
    .irq(irq),
`endif
    .clk32(clk32), .reset(reset), .clk_en(clk_en),
    .FCS_N(FCS_N), .RW(RW), .A1(A1), .DIN(DIN), .DOUT(DOUT),
    .RDY_I(RDY_I), .RDY_O(RDY_O),
    .dev_rd_valid(dev_rd_valid), .dev_rd_ready(dev_rd_ready), .dev_rd_data(dev_rd_data),
    .dev_wr_valid(dev_wr_valid), .dev_wr_ready(dev_wr_ready), .dev_wr_data(dev_wr_data)
  );

  always #5 clk32 = ~clk32;

  // clk_en is high one cycle in four, changing only after posedges.
  logic [1:0] en_cnt = 2'd0;
  always @(posedge clk32) en_cnt <= en_cnt + 2'd1;
  assign clk_en = (en_cnt == 2'd3);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // All tasks start and end at a negedge.
  task automatic cpu_write(input logic a1, input logic [15:0] d);
    FCS_N = 1'b0; RW = 1'b0; A1 = a1; DIN = d;
    repeat (8) @(negedge clk32);   // spans two clk_en pulses
    FCS_N = 1'b1; RW = 1'b1;
    repeat (2) @(negedge clk32);
  endtask

  task automatic cpu_read(input logic a1, output logic [15:0] d);
    FCS_N = 1'b0; RW = 1'b1; A1 = a1;
    #1 d = DOUT;
    @(negedge clk32);
    FCS_N = 1'b1;
  endtask

  task automatic strobe(input logic [15:0] d);
    while (!clk_en) @(negedge clk32);
    DIN = d; RDY_I = 1'b0;
    @(negedge clk32);
    RDY_I = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    dev_rd_valid = 1'b1; dev_rd_data = b;
    while (!dev_rd_ready && n < 200) begin @(negedge clk32); n++; end
    if (!dev_rd_ready) timeout_fail("dev_rd_ready");
    @(negedge clk32);
    dev_rd_valid = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] exp);
    int n = 0;
    while (!dev_wr_valid && n < 200) begin @(negedge clk32); n++; end
    if (!dev_wr_valid) timeout_fail("dev_wr_valid");
    else chk("dev_wr_data", {8'h00, dev_wr_data}, {8'h00, exp});
    dev_wr_ready = 1'b1;
    @(negedge clk32);
    dev_wr_ready = 1'b0;
  endtask

  // Drain one read-direction burst whose first byte index is base.
  task automatic drain_read(input int base);
    logic [7:0] hi, lo;
    repeat (2) @(negedge clk32);
    for (int i = 0; i < 8; i++) begin
      hi = 8'(base + 2*i);
      lo = 8'(base + 2*i + 1);
      chk("burst word", DOUT, {hi, lo});
      strobe(16'h0000);
      if (i == 6) chk("RDY_O before last word", {15'h0, RDY_O}, 16'h0000);
    end
    chk("RDY_O after 8 words", {15'h0, RDY_O}, 16'h0001);
  endtask

  typedef struct {
    logic        wr;
    logic        a1;
    logic [15:0] data;   // write value, or expected read value
    string       name;
  } reg_vec_t;

  reg_vec_t rv[11];
  logic [15:0] v;

  initial begin
    rv[0]  = '{1'b1, 1'b1, 16'h0010, "wr mode"};
    rv[1]  = '{1'b1, 1'b0, 16'h0002, "wr sc"};
    rv[2]  = '{1'b0, 1'b0, 16'h0002, "rd sc"};
    rv[3]  = '{1'b0, 1'b1, 16'h0003, "rd status"};
    rv[4]  = '{1'b1, 1'b0, 16'h12FF, "wr sc hi bits"};
    rv[5]  = '{1'b0, 1'b0, 16'h00FF, "rd sc masked"};
    rv[6]  = '{1'b1, 1'b1, 16'h0000, "wr mode bit4 off"};
    rv[7]  = '{1'b0, 1'b0, 16'h0000, "rd sc hidden"};
    rv[8]  = '{1'b1, 1'b0, 16'h0055, "wr sc ignored"};
    rv[9]  = '{1'b1, 1'b1, 16'h0010, "wr mode bit4 on"};
    rv[10] = '{1'b0, 1'b0, 16'h00FF, "rd sc kept"};

    // Reset state
    repeat (3) @(negedge clk32);
    reset = 1'b0;
    @(negedge clk32);
    chk("reset RDY_O", {15'h0, RDY_O}, 16'h0001);
    chk("reset DOUT", DOUT, 16'h0000);
    chk("reset dev_rd_ready", {15'h0, dev_rd_ready}, 16'h0000);
    chk("reset dev_wr_valid", {15'h0, dev_wr_valid}, 16'h0000);
    cpu_read(1'b1, v); chk("reset status", v, 16'h0001);
`ifdef DMA_DONE_IRQ_EN
    chk("reset irq", {15'h0, irq}, 16'h0000);
`endif

    // Register access table
    foreach (rv[i]) begin
      if (rv[i].wr) cpu_write(rv[i].a1, rv[i].data);
      else begin
        cpu_read(rv[i].a1, v);
        chk(rv[i].name, v, rv[i].data);
      end
    end

    // Read-direction burst and sector end: sc=1, 512 bytes in 32 bursts
    cpu_write(1'b0, 16'h0001);
    for (int blk = 0; blk < 32; blk++) begin
      if (blk == 31) begin
        cpu_read(1'b0, v); chk("sc before last block", v, 16'h0001);
      end
      for (int k = 0; k < 16; k++) begin
        if (blk == 0 && k == 15) chk("RDY_O before 16th byte", {15'h0, RDY_O}, 16'h0001);
        send_byte(8'(blk*16 + k));
      end
      if (blk == 0) begin
        repeat (2) @(negedge clk32);
        chk("first head word", DOUT, 16'h0001);
        chk("rd_ready in burst", {15'h0, dev_rd_ready}, 16'h0000);
      end
      if (blk == 31) begin
        repeat (2) @(negedge clk32);
        cpu_read(1'b1, v); chk("status at sector end", v, 16'h0005);
        cpu_read(1'b0, v); chk("sc at sector end", v, 16'h0000);
`ifdef DMA_DONE_IRQ_EN
        chk("irq at sector end", {15'h0, irq}, 16'h0001);
`endif
      end
      drain_read(blk*16);
    end
    repeat (2) @(negedge clk32);
    chk("rd_ready stalled sc=0", {15'h0, dev_rd_ready}, 16'h0000);
    cpu_read(1'b1, v); chk("status after drain", v, 16'h0001);

    // Direction toggle clears FIFO, byte counter and sc
    cpu_write(1'b0, 16'h0001);
    for (int k = 0; k < 3; k++) send_byte(8'hE0 + 8'(k));
    cpu_write(1'b1, 16'h0110);
    cpu_read(1'b0, v); chk("sc after toggle", v, 16'h0000);
    chk("RDY_O after toggle", {15'h0, RDY_O}, 16'h0001);
    chk("fifo cleared", {15'h0, dev_wr_valid}, 16'h0000);
`ifdef DMA_DONE_IRQ_EN
    chk("irq cleared by mode wr", {15'h0, irq}, 16'h0000);
`endif

    // Write-direction burst
    cpu_write(1'b0, 16'h0001);
    chk("RDY_O write burst", {15'h0, RDY_O}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      chk("no drain during burst", {15'h0, dev_wr_valid}, 16'h0000);
      strobe(16'hA1B2 + 16'(i) * 16'h0202);
    end
    chk("RDY_O after write burst", {15'h0, RDY_O}, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      recv_byte(8'hA1 + 8'(2*i));
      recv_byte(8'hB2 + 8'(2*i));
    end
    repeat (2) @(negedge clk32);
    chk("next write burst", {15'h0, RDY_O}, 16'h0000);

    // Abort by direction change, then error flag
    cpu_write(1'b1, 16'h0010);
    chk("RDY_O after abort", {15'h0, RDY_O}, 16'h0001);
    strobe(16'h0000);
    cpu_read(1'b1, v); chk("status error", v, 16'h0000);
    cpu_write(1'b1, 16'h0110);
    cpu_read(1'b1, v); chk("status error cleared", v, 16'h0001);

    // Reset in the middle of a write burst
    cpu_write(1'b0, 16'h0002);
    for (int i = 0; i < 3; i++) strobe(16'h5566);
    chk("RDY_O mid burst", {15'h0, RDY_O}, 16'h0000);
    reset = 1'b1;
    repeat (2) @(negedge clk32);
    reset = 1'b0;
    @(negedge clk32);
    chk("mid reset RDY_O", {15'h0, RDY_O}, 16'h0001);
    chk("mid reset DOUT", DOUT, 16'h0000);
    chk("mid reset dev_rd_ready", {15'h0, dev_rd_ready}, 16'h0000);
    chk("mid reset dev_wr_valid", {15'h0, dev_wr_valid}, 16'h0000);
    cpu_read(1'b1, v); chk("mid reset status", v, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
